// File: rtl/enet_rx_reg_bridge.sv
// Host-side register bridge for the receive MAC: forwards accesses to the RX command FIFO,
// drains the RX response FIFO, and owns the sticky RX interrupt-event register (EIR).
module enet_rx_reg_bridge #(
  parameter int unsigned RSP_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_req_valid,
  output logic        reg_req_ready,
  input  logic        reg_req_write,
  input  logic [11:0] reg_req_addr,
  input  logic [31:0] reg_req_wdata,
  output logic        reg_rsp_valid,
  output logic [31:0] reg_rsp_rdata,
  output logic        reg_rsp_err,
  input  logic        cmd_full,
  output logic        cmd_wen,
  output logic [44:0] cmd_data,
  input  logic        rsp_empty,
  output logic        rsp_ren,
  input  logic [43:0] rsp_data,
  input  logic [31:0] eimr,
  output logic [31:0] eir_rx,
  output logic        irq_rx
);

  localparam int unsigned CW        = $clog2(RSP_TIMEOUT + 1);
  localparam logic [11:0] EIR_ADDR  = 12'h004;
  localparam logic [11:0] RDAR_ADDR = 12'h010;
  localparam logic [11:0] RCR_ADDR  = 12'h084;

  typedef enum logic [1:0] {IDLE, PUSH, WAIT_RSP, DONE} state_t;

  state_t        state;
  logic          is_write;
  logic [11:0]   addr;
  logic [CW-1:0] cnt;

  logic          hs;
  logic          pop_eir;
  logic          pop_match;
  logic [31:0]   evt;

  // FIFO strobes follow the full/empty flags combinationally so they can never violate them.
  assign hs        = reg_req_valid && reg_req_ready;
  assign rsp_ren   = !rst && !rsp_empty;
  assign cmd_wen   = !rst && (state == PUSH) && !cmd_full;
  assign pop_eir   = rsp_ren && (rsp_data[11:0] == EIR_ADDR);
  assign pop_match = rsp_ren && (rsp_data[11:0] == addr);
  assign evt       = pop_eir ? rsp_data[43:12] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      is_write      <= 1'b0;
      addr          <= 12'h0;
      cnt           <= '0;
      reg_req_ready <= 1'b0;
      reg_rsp_valid <= 1'b0;
      reg_rsp_rdata <= 32'h0;
      reg_rsp_err   <= 1'b0;
      cmd_data      <= 45'h0;
      eir_rx        <= 32'h0;
      irq_rx        <= 1'b0;
    end else begin
      irq_rx <= |(eir_rx & eimr);
      // Drained EIR events always merge in; a same-cycle W1C below still lets the event win.
      eir_rx <= eir_rx | evt;

      case (state)
        IDLE: begin
          reg_req_ready <= !hs;
          if (hs) begin
            is_write <= reg_req_write;
            addr     <= reg_req_addr;
            if (reg_req_write && (reg_req_addr == EIR_ADDR)) begin
              eir_rx        <= (eir_rx & ~reg_req_wdata) | evt;
              reg_rsp_valid <= 1'b1;
              reg_rsp_rdata <= 32'h0;
              state         <= DONE;
            end else if (reg_req_write) begin
              cmd_data <= {reg_req_wdata, reg_req_addr, 1'b0};
              state    <= PUSH;
            end else if ((reg_req_addr == RDAR_ADDR) || (reg_req_addr == RCR_ADDR)) begin
              cmd_data <= {32'h0, reg_req_addr, 1'b1};
              state    <= PUSH;
            end else begin
              reg_rsp_valid <= 1'b1;
              reg_rsp_rdata <= (reg_req_addr == EIR_ADDR) ? eir_rx : 32'h0;
              state         <= DONE;
            end
          end
        end

        PUSH: begin
          if (!cmd_full) begin
            cmd_data <= 45'h0;
            if (is_write) begin
              reg_rsp_valid <= 1'b1;
              reg_rsp_rdata <= 32'h0;
              state         <= DONE;
            end else begin
              cnt   <= '0;
              state <= WAIT_RSP;
            end
          end
        end

        WAIT_RSP: begin
          if (pop_match) begin
            reg_rsp_valid <= 1'b1;
            reg_rsp_rdata <= rsp_data[43:12];
            state         <= DONE;
          end else if (cnt == CW'(RSP_TIMEOUT)) begin
            reg_rsp_valid <= 1'b1;
            reg_rsp_rdata <= 32'h0;
            reg_rsp_err   <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          reg_rsp_valid <= 1'b0;
          reg_rsp_rdata <= 32'h0;
          reg_rsp_err   <= 1'b0;
          reg_req_ready <= 1'b1;
          state         <= IDLE;
        end

        default: begin
          reg_req_ready <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enet_rx_reg_bridge.sv
// Scoreboard bench for enet_rx_reg_bridge: directed accesses, modelled FIFOs,
// and monitors that check every command push and host response against queued expectations.
module tb_enet_rx_reg_bridge;

  localparam int unsigned TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_req_valid;
  logic        reg_req_ready;
  logic        reg_req_write;
  logic [11:0] reg_req_addr;
  logic [31:0] reg_req_wdata;
  logic        reg_rsp_valid;
  logic [31:0] reg_rsp_rdata;
  logic        reg_rsp_err;
  logic        cmd_full;
  logic        cmd_wen;
  logic [44:0] cmd_data;
  logic        rsp_empty;
  logic        rsp_ren;
  logic [43:0] rsp_data;
  logic [31:0] eimr;
  logic [31:0] eir_rx;
  logic        irq_rx;

  enet_rx_reg_bridge #(.RSP_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .reg_req_valid(reg_req_valid), .reg_req_ready(reg_req_ready),
    .reg_req_write(reg_req_write), .reg_req_addr(reg_req_addr), .reg_req_wdata(reg_req_wdata),
    .reg_rsp_valid(reg_rsp_valid), .reg_rsp_rdata(reg_rsp_rdata), .reg_rsp_err(reg_rsp_err),
    .cmd_full(cmd_full), .cmd_wen(cmd_wen), .cmd_data(cmd_data),
    .rsp_empty(rsp_empty), .rsp_ren(rsp_ren), .rsp_data(rsp_data),
    .eimr(eimr), .eir_rx(eir_rx), .irq_rx(irq_rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int n_rsp = 0;
  int n_cmd = 0;
  int n_pop = 0;
  int rsp_cyc = 0;
  int cmd_cyc = 0;

  logic [32:0] exp_rsp[$];
  logic [44:0] exp_cmd[$];
  logic [43:0] rsp_q[$];
  bit          do_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void rsp_upd();
    rsp_empty = (rsp_q.size() == 0);
    rsp_data  = rsp_empty ? 44'h0 : rsp_q[0];
  endfunction

  function automatic void rsp_push(input logic [31:0] d, input logic [11:0] a);
    rsp_q.push_back({d, a});
    rsp_upd();
  endfunction

  // Response FIFO model: the pop decided in a cycle takes effect just after the edge.
  always begin
    @(negedge clk);
    do_pop = rsp_ren;
    @(posedge clk);
    #1;
    if (do_pop && rsp_q.size() > 0) rsp_q.delete(0);
    rsp_upd();
  end

  // Monitors: FIFO protocol, command pushes and host responses.
  always @(negedge clk) begin
    if (rsp_ren) begin
      n_pop++;
      if (rsp_empty) begin
        n_bad++;
        $display("FAIL rsp_ren_while_empty at cycle %0d", cyc);
      end
    end
    if (cmd_wen) begin
      n_cmd++;
      cmd_cyc = cyc;
      if (cmd_full) begin
        n_bad++;
        $display("FAIL cmd_wen_while_full at cycle %0d", cyc);
      end
      if (exp_cmd.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_cmd: got %h at cycle %0d", cmd_data, cyc);
      end else begin
        chk("cmd_data", 64'(cmd_data), 64'(exp_cmd.pop_front()));
      end
    end
    if (reg_rsp_valid) begin
      n_rsp++;
      rsp_cyc = cyc;
      if (exp_rsp.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rsp: got err=%b rdata=%h at cycle %0d", reg_rsp_err, reg_rsp_rdata, cyc);
      end else begin
        chk("rsp_err_rdata", 64'({reg_rsp_err, reg_rsp_rdata}), 64'(exp_rsp.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d, output int t);
    int k = 0;
    while (!reg_req_ready && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) begin
      n_vec++;
      n_bad++;
      $display("FAIL issue_ready: ready stayed %b, required 1", reg_req_ready);
    end
    reg_req_valid = 1'b1;
    reg_req_write = w;
    reg_req_addr  = a;
    reg_req_wdata = d;
    t = cyc;
    tick();
    reg_req_valid = 1'b0;
    reg_req_write = 1'b0;
    reg_req_addr  = 12'h0;
    reg_req_wdata = 32'h0;
  endtask

  task automatic wait_rsp(input int n0, input int budget);
    int k = 0;
    while (n_rsp == n0 && k < budget) begin
      tick();
      k++;
    end
    if (n_rsp == n0) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_rsp: no response within %0d cycles, required one", budget);
    end
  endtask

  task automatic wait_cmd(input int n0, input int budget);
    int k = 0;
    while (n_cmd == n0 && k < budget) begin
      tick();
      k++;
    end
    if (n_cmd == n0) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_cmd: no push within %0d cycles, required one", budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n0;
    int c0;
    int p0;
    int tp;

    rst = 1'b1;
    reg_req_valid = 1'b0;
    reg_req_write = 1'b0;
    reg_req_addr  = 12'h0;
    reg_req_wdata = 32'h0;
    cmd_full = 1'b0;
    eimr = 32'h0;
    rsp_upd();

    // Reset state
    repeat (2) tick();
    chk("reset_ctl", 64'({reg_req_ready, reg_rsp_valid, reg_rsp_err, cmd_wen, rsp_ren, irq_rx}), 64'h0);
    chk("reset_data", {reg_rsp_rdata, eir_rx}, 64'h0);
    chk("reset_cmd_data", 64'(cmd_data), 64'h0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 64'(reg_req_ready), 64'h1);

    // Forwarded RCR read, response 5 cycles after the push
    exp_cmd.push_back({32'h0, 12'h084, 1'b1});
    exp_rsp.push_back({1'b0, 32'h0000_0C04});
    n0 = n_rsp;
    c0 = n_cmd;
    issue(1'b0, 12'h084, 32'h0, t);
    wait_cmd(c0, 10);
    chk("rcr_cmd_cycle", 64'(cmd_cyc), 64'(t + 1));
    while (cyc < cmd_cyc + 5) tick();
    rsp_push(32'h0000_0C04, 12'h084);
    tp = cyc;
    wait_rsp(n0, 40);
    chk("rcr_rsp_cycle", 64'(rsp_cyc), 64'(tp + 1));

    // Local reads
    n0 = n_rsp;
    exp_rsp.push_back({1'b0, 32'h0});
    issue(1'b0, 12'h200, 32'h0, t);
    wait_rsp(n0, 10);
    chk("local_read_cycle", 64'(rsp_cyc), 64'(t + 1));
    n0 = n_rsp;
    exp_rsp.push_back({1'b0, 32'h0});
    issue(1'b0, 12'h004, 32'h0, t);
    wait_rsp(n0, 10);
    chk("eir_read_cycle", 64'(rsp_cyc), 64'(t + 1));

    // Forwarded write, FIFO not full
    n0 = n_rsp;
    exp_cmd.push_back({32'hABCD_0123, 12'h300, 1'b0});
    exp_rsp.push_back({1'b0, 32'h0});
    issue(1'b1, 12'h300, 32'hABCD_0123, t);
    wait_rsp(n0, 10);
    chk("fwd_write_rsp_cycle", 64'(rsp_cyc), 64'(t + 2));

    // RDAR write with cmd_full high for 3 cycles
    n0 = n_rsp;
    c0 = n_cmd;
    exp_cmd.push_back({32'h0100_0000, 12'h010, 1'b0});
    exp_rsp.push_back({1'b0, 32'h0});
    cmd_full = 1'b1;
    issue(1'b1, 12'h010, 32'h0100_0000, t);
    tick();
    tick();
    tick();
    cmd_full = 1'b0;
    wait_rsp(n0, 10);
    chk("full_cmd_cycle", 64'(cmd_cyc), 64'(t + 4));
    chk("full_rsp_cycle", 64'(rsp_cyc), 64'(t + 5));
    chk("full_cmd_count", 64'(n_cmd - c0), 64'h1);

    // EIR event followed by matching RDAR response during a pending read
    eimr = 32'h0200_0000;
    n0 = n_rsp;
    c0 = n_cmd;
    exp_cmd.push_back({32'h0, 12'h010, 1'b1});
    exp_rsp.push_back({1'b0, 32'h0000_0001});
    issue(1'b0, 12'h010, 32'h0, t);
    wait_cmd(c0, 10);
    rsp_push(32'h0200_0000, 12'h004);
    rsp_push(32'h0000_0001, 12'h010);
    wait_rsp(n0, 40);
    tick();
    chk("eir_after_event", 64'(eir_rx), 64'h0200_0000);
    chk("irq_masked_event", 64'(irq_rx), 64'h1);

    // Background EIR event while idle, then W1C racing an event on the same bit
    rsp_push(32'h0800_0000, 12'h004);
    repeat (3) tick();
    chk("eir_idle_event", 64'(eir_rx), 64'h0A00_0000);
    n0 = n_rsp;
    exp_rsp.push_back({1'b0, 32'h0});
    rsp_push(32'h0800_0000, 12'h004);
    issue(1'b1, 12'h004, 32'h0800_0000, t);
    wait_rsp(n0, 10);
    chk("eir_w1c_race", 64'(eir_rx), 64'h0A00_0000);
    n0 = n_rsp;
    exp_rsp.push_back({1'b0, 32'h0});
    issue(1'b1, 12'h004, 32'h0800_0000, t);
    wait_rsp(n0, 10);
    chk("eir_w1c_plain", 64'(eir_rx), 64'h0200_0000);
    n0 = n_rsp;
    exp_rsp.push_back({1'b0, 32'h0200_0000});
    issue(1'b0, 12'h004, 32'h0, t);
    wait_rsp(n0, 10);

    // Read timeout, then a late response is drained and discarded
    n0 = n_rsp;
    exp_cmd.push_back({32'h0, 12'h084, 1'b1});
    exp_rsp.push_back({1'b1, 32'h0});
    issue(1'b0, 12'h084, 32'h0, t);
    wait_rsp(n0, 40);
    chk("timeout_cycle", 64'(rsp_cyc), 64'(t + 18));
    p0 = n_pop;
    n0 = n_rsp;
    rsp_push(32'hDEAD_BEEF, 12'h084);
    repeat (4) tick();
    chk("late_rsp_pops", 64'(n_pop - p0), 64'h1);
    chk("late_rsp_drained", 64'(rsp_q.size()), 64'h0);
    chk("late_rsp_no_host_rsp", 64'(n_rsp - n0), 64'h0);
    chk("late_rsp_eir", 64'(eir_rx), 64'h0200_0000);

    // Reset during WAIT_RSP with a response entry pending
    c0 = n_cmd;
    n0 = n_rsp;
    exp_cmd.push_back({32'h0, 12'h010, 1'b1});
    issue(1'b0, 12'h010, 32'h0, t);
    wait_cmd(c0, 10);
    tick();
    rst = 1'b1;
    rsp_push(32'h1234_5678, 12'h010);
    tick();
    chk("midop_reset_ctl", 64'({reg_req_ready, reg_rsp_valid, reg_rsp_err, cmd_wen, rsp_ren, irq_rx}), 64'h0);
    chk("midop_reset_data", {reg_rsp_rdata, eir_rx}, 64'h0);
    rst = 1'b0;
    repeat (4) tick();
    chk("midop_drained", 64'(rsp_q.size()), 64'h0);
    chk("midop_no_rsp", 64'(n_rsp - n0), 64'h0);
    chk("midop_rdata", 64'(reg_rsp_rdata), 64'h0);
    n0 = n_rsp;
    exp_rsp.push_back({1'b0, 32'h0});
    issue(1'b0, 12'h004, 32'h0, t);
    wait_rsp(n0, 10);

    repeat (3) tick();
    chk("exp_rsp_left", 64'(exp_rsp.size()), 64'h0);
    chk("exp_cmd_left", 64'(exp_cmd.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/enet_rx_reg_bridge.md
# enet_rx_reg_bridge

Host-clock-domain register bridge for the receive MAC. Accepts single 32-bit register accesses from the ENET register decoder, packs forwarded ones into 45-bit command words for the RX command CDC FIFO, and drains the 44-bit RX response FIFO. It returns read data to the host, maintains the sticky RX interrupt-event register (EIR, offset 0x004) with write-1-to-clear semantics, and drives the RX interrupt line.

## Interface
- RSP_TIMEOUT, 1023: cycles to wait in WAIT_RSP before a forwarded read completes with an error.
- clk  in  1  bus-side clock; every register updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- reg_req_valid  in  1  host access request.
- reg_req_ready  out  1  high only in IDLE.
- reg_req_write  in  1  1 = write, 0 = read.
- reg_req_addr  in  12  byte offset.
- reg_req_wdata  in  32  write data.
- reg_rsp_valid  out  1  one-cycle completion pulse, for reads and writes.
- reg_rsp_rdata  out  32  read data; 0 on writes.
- reg_rsp_err  out  1  qualifies reg_rsp_valid; set on timeout only.
- cmd_full  in  1  command FIFO full.
- cmd_wen  out  1  command FIFO push.
- cmd_data  out  45  {wdata[31:0], addr[11:0], is_read}.
- rsp_empty  in  1  response FIFO empty.
- rsp_ren  out  1  response FIFO pop; show-ahead, so data is valid while !rsp_empty.
- rsp_data  in  44  {data[31:0], addr[11:0]}.
- eimr  in  32  interrupt mask, from the shared mask register.
- eir_rx  out  32  sticky EIR.
- irq_rx  out  1  |(eir_rx & eimr), registered.

## Operation
- States: IDLE, PUSH, WAIT_RSP, DONE.
- IDLE
  - Request handshake is reg_req_valid & reg_req_ready; on handshake, latch write, addr and wdata.
  - Local accesses go to DONE:
    - Write to 0x004: eir_rx <= eir_rx & ~wdata.
    - Read of 0x004: rdata = eir_rx.
    - Read of any address other than 0x004, 0x010 or 0x084: rdata = 0.
  - Writes to any other address are forwarded and go to PUSH.
  - Reads of 0x010 (RDAR) and 0x084 (RCR) are forwarded and go to PUSH.
- PUSH
  - cmd_wen = !cmd_full. cmd_data = {wdata, addr, ~write}; wdata field is 0 for reads.
  - On push: write goes to DONE; read goes to WAIT_RSP with the timeout counter cleared.
  - While cmd_full is high, hold in PUSH with no timeout.
- WAIT_RSP
  - When !rsp_empty, always pop (rsp_ren = 1).
  - Entry addr == 0x004: EIR event; OR data into eir_rx and stay.
  - Entry addr == latched addr: capture data into rdata, go to DONE.
  - Any other entry: discard and stay.
  - Counter increments each cycle with no match. When it reaches RSP_TIMEOUT: rdata = 0, err = 1, go to DONE. A late response arriving after that is discarded by the background drain.
- DONE: reg_rsp_valid = 1 for one cycle with rdata/err, then IDLE; rdata and err clear.
- Background drain, in all states except WAIT_RSP:
  - rsp_ren = !rsp_empty.
  - EIR entries (addr 0x004) are ORed into eir_rx.
  - All other entries are discarded.
- Simultaneous W1C clear and EIR event in the same cycle: eir_rx <= (eir_rx & ~wdata) | event_data, so the event wins.
- Counter width: $clog2(RSP_TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset: state IDLE. All outputs 0, including reg_req_ready. eir_rx = 0, irq_rx = 0, counter = 0. reg_req_ready rises the cycle after rst deasserts.
- Reset mid-operation: the transaction is abandoned with no response. FIFO contents are not flushed; the drain discards stale entries.
- Local access, handshake at cycle T: reg_rsp_valid at T+1.
- Forwarded write, handshake at T, FIFO not full: cmd_wen at T+1, reg_rsp_valid at T+2. Each cycle of cmd_full adds one cycle.
- Forwarded read: cmd_wen at T+1. A matching pop at cycle P gives reg_rsp_valid at P+1.
- irq_rx lags eir_rx/eimr changes by one cycle.
- cmd_wen is never asserted while cmd_full is high. rsp_ren is never asserted while rsp_empty is high.

## Test plan
- Read 0x084 with the responder returning {32'h0000_0C04, 12'h084} 5 cycles after the push:
  - cmd_data = {32'h0, 12'h084, 1'b1}.
  - reg_rsp_rdata = 32'h0000_0C04, err = 0, one cycle after the pop.
- Write 0x010 = 32'h0100_0000 with cmd_full high for 3 cycles:
  - cmd_wen exactly once, at T+4, with cmd_data = {32'h0100_0000, 12'h010, 1'b0}.
  - reg_rsp_valid at T+5.
- Response FIFO holds {32'h0200_0000, 12'h004} then {32'h0000_0001, 12'h010} during a pending RDAR read:
  - eir_rx = 32'h0200_0000.
  - rdata = 32'h0000_0001.
  - With eimr = 32'h0200_0000, irq_rx = 1.
- eir_rx = 32'h0A00_0000, host writes 0x004 = 32'h0800_0000 in the same cycle a 32'h0800_0000 event pops:
  - eir_rx = 32'h0A00_0000.
  - The following W1C with no event gives 32'h0200_0000.
- Read 0x084 with no response and RSP_TIMEOUT = 15:
  - reg_rsp_valid with err = 1, rdata = 0, 16 cycles after entering WAIT_RSP.
  - A later {x, 12'h084} entry is popped and discarded.
- Assert rst during WAIT_RSP:
  - Next cycle: all outputs 0, state IDLE, no reg_rsp_valid.
  - A pending response entry is drained without updating rdata.
